// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
// Covers the sequencer states, common flash opcodes and the address length.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_HOLD
    } seq_state_t;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_WAKE = 8'hAB;

    localparam int         ADDR_BYTES = 3;
    localparam logic [7:0] DUMMY_BYTE = 8'h00;

endpackage

// File: rtl/spi_xfer_sequencer_arb.sv
// Two-way round-robin arbiter. It prefers the requester that was not granted last.
// The grant is combinational, and the pointer advances on every grant it issues.
module spi_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic       o_gnt_valid,
    output logic       o_gnt_id
);

    logic r_last;
    logic w_other;

    assign w_other = ~r_last;

    always_comb begin
        // NOTE: outputs get a default before any branch so no path holds a stale value (no latch).
        o_gnt_valid = 1'b0;
        o_gnt_id    = w_other;
        if (i_en) begin
            if (i_req[w_other]) begin
                o_gnt_valid = 1'b1;
                o_gnt_id    = w_other;
            end else if (i_req[r_last]) begin
                o_gnt_valid = 1'b1;
                o_gnt_id    = r_last;
            end
        end
    end

    // Pointer starts at 1 so requester 0 wins the first contest after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (o_gnt_valid) begin
            r_last <= o_gnt_id;
        end
    end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Command-level SPI sequencer. It arbitrates two requesters and frames each transaction
// as: chip select, opcode, optional 24-bit address, N read bytes, then chip-select release.
module spi_xfer_sequencer
    import spi_seq_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int LEN_W    = 8,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic                   core_clk,
    input  logic                   core_rstn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*8-1:0]      req_opcode,
    input  logic [NREQ*24-1:0]     req_addr,
    input  logic [NREQ-1:0]        req_addr_en,
    input  logic [NREQ*LEN_W-1:0]  req_rlen,
    output logic                   rx_valid,
    output logic [7:0]             rx_data,
    output logic                   rx_id,
    output logic                   rx_last,
    output logic                   busy,
    output logic                   eng_start,
    output logic [7:0]             eng_tx,
    input  logic                   eng_done,
    input  logic [7:0]             eng_rx,
    output logic                   spi_cs_n
);

    localparam int         CNT_MAX    = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int         CNT_W      = $clog2(CNT_MAX + 1);
    localparam logic [1:0] LAST_ABYTE = 2'(ADDR_BYTES - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_abyte;
    logic [LEN_W-1:0] r_rem;
    logic [7:0]       r_op;
    logic [23:0]      r_addr;
    logic             r_addr_en;
    logic             r_owner;

    logic             w_gnt_valid;
    logic             w_gnt_id;
    logic [7:0]       w_op;
    logic [23:0]      w_addr;
    logic             w_aen;
    logic [LEN_W-1:0] w_rlen;

    spi_rr_arbiter2 u_arb (
        .clk         (core_clk),
        .rst_n       (core_rstn),
        .i_en        (r_state == ST_IDLE),
        .i_req       (req_valid),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_id    (w_gnt_id)
    );

    // Descriptor of the winning requester, latched on the grant edge.
    always_comb begin
        w_op   = req_opcode[7:0];
        w_addr = req_addr[23:0];
        w_aen  = req_addr_en[0];
        w_rlen = req_rlen[LEN_W-1:0];
        if (w_gnt_id) begin
            w_op   = req_opcode[15:8];
            w_addr = req_addr[47:24];
            w_aen  = req_addr_en[1];
            w_rlen = req_rlen[2*LEN_W-1:LEN_W];
        end
    end

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_abyte   <= '0;
            r_rem     <= '0;
            r_op      <= '0;
            r_addr    <= '0;
            r_addr_en <= 1'b0;
            r_owner   <= 1'b0;
            req_ready <= '0;
            rx_valid  <= 1'b0;
            rx_data   <= '0;
            rx_id     <= 1'b0;
            rx_last   <= 1'b0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
            eng_tx    <= '0;
            spi_cs_n  <= 1'b1;
        end else begin
            // NOTE: state and registered outputs use non-blocking assignments so every read sees pre-edge values.
            eng_start <= 1'b0;
            rx_valid  <= 1'b0;
            rx_last   <= 1'b0;
            req_ready <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        req_ready <= {w_gnt_id, ~w_gnt_id};
                        r_owner   <= w_gnt_id;
                        r_op      <= w_op;
                        r_addr    <= w_addr;
                        r_addr_en <= w_aen;
                        r_rem     <= w_rlen;
                        r_cnt     <= CNT_W'(CS_SETUP - 1);
                        spi_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        eng_start <= 1'b1;
                        eng_tx    <= r_op;
                        r_state   <= ST_CMD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_CMD: begin
                    if (eng_done) begin
                        if (r_addr_en) begin
                            eng_start <= 1'b1;
                            eng_tx    <= r_addr[23:16];
                            r_addr    <= {r_addr[15:0], 8'h00};
                            r_abyte   <= '0;
                            r_state   <= ST_ADDR;
                        end else if (r_rem != '0) begin
                            eng_start <= 1'b1;
                            eng_tx    <= DUMMY_BYTE;
                            r_state   <= ST_READ;
                        end else begin
                            r_cnt   <= CNT_W'(CS_HOLD - 1);
                            r_state <= ST_HOLD;
                        end
                    end
                end

                ST_ADDR: begin
                    if (eng_done) begin
                        if (r_abyte != LAST_ABYTE) begin
                            eng_start <= 1'b1;
                            eng_tx    <= r_addr[23:16];
                            r_addr    <= {r_addr[15:0], 8'h00};
                            r_abyte   <= r_abyte + 2'd1;
                        end else if (r_rem != '0) begin
                            eng_start <= 1'b1;
                            eng_tx    <= DUMMY_BYTE;
                            r_state   <= ST_READ;
                        end else begin
                            r_cnt   <= CNT_W'(CS_HOLD - 1);
                            r_state <= ST_HOLD;
                        end
                    end
                end

                // r_rem counts bytes not yet completed, including the one in flight.
                ST_READ: begin
                    if (eng_done) begin
                        rx_valid <= 1'b1;
                        rx_data  <= eng_rx;
                        rx_id    <= r_owner;
                        if (r_rem == LEN_W'(1)) begin
                            rx_last <= 1'b1;
                            r_cnt   <= CNT_W'(CS_HOLD - 1);
                            r_state <= ST_HOLD;
                        end else begin
                            r_rem     <= r_rem - 1'b1;
                            eng_start <= 1'b1;
                            eng_tx    <= DUMMY_BYTE;
                        end
                    end
                end

                ST_HOLD: begin
                    if (r_cnt == '0) begin
                        spi_cs_n <= 1'b1;
                        busy     <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Self-checking bench for spi_xfer_sequencer. It combines a byte-engine/flash model,
// scoreboard queues for transmitted and received bytes, and chip-select timing monitors.
`timescale 1ns/1ps
module tb_spi_xfer_sequencer;
    import spi_seq_pkg::*;

    localparam int NREQ     = 2;
    localparam int LEN_W    = 8;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int ENG_LAT  = 3;
    localparam int BYTE_T   = ENG_LAT + 1;

    logic                  core_clk = 1'b0;
    logic                  core_rstn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*8-1:0]     req_opcode;
    logic [NREQ*24-1:0]    req_addr;
    logic [NREQ-1:0]       req_addr_en;
    logic [NREQ*LEN_W-1:0] req_rlen;
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_id;
    logic                  rx_last;
    logic                  busy;
    logic                  eng_start;
    logic [7:0]            eng_tx;
    logic                  eng_done;
    logic [7:0]            eng_rx;
    logic                  spi_cs_n;

    spi_xfer_sequencer #(
        .NREQ(NREQ), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)
    ) dut (
        .core_clk    (core_clk),
        .core_rstn   (core_rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_opcode  (req_opcode),
        .req_addr    (req_addr),
        .req_addr_en (req_addr_en),
        .req_rlen    (req_rlen),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_id       (rx_id),
        .rx_last     (rx_last),
        .busy        (busy),
        .eng_start   (eng_start),
        .eng_tx      (eng_tx),
        .eng_done    (eng_done),
        .eng_rx      (eng_rx),
        .spi_cs_n    (spi_cs_n)
    );

    always #5 core_clk = ~core_clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
        logic       last;
    } rx_exp_t;

    rx_exp_t    rx_exp_q[$];
    logic [7:0] tx_exp_q[$];
    int         grant_log[$];
    logic [7:0] mem [256];

    int cyc = 0;
    int rx_cnt = 0, rx_last_cnt = 0, start_cnt = 0, cs_fall_cnt = 0, cs_low_cyc = 0;
    int t_cs_fall = 0, t_done_drive = 0;

    always @(posedge core_clk) cyc <= cyc + 1;

    // Flash content returned by the engine model for a byte at position k of a transaction.
    function automatic logic [7:0] flash_byte(input logic [7:0] op, input logic [23:0] addr, input int k);
        if (op == OP_READ && k >= 4) return mem[(int'(addr[7:0]) + k - 4) % 256];
        if (op == OP_RDID && k >= 1) return mem[(k - 1) % 256];
        return 8'h5A ^ 8'(k);
    endfunction

    // Byte engine: accepts a start, checks the byte held stable, answers after ENG_LAT cycles.
    int         eng_wait = 0;
    int         eng_k    = 0;
    logic [7:0] eng_hold_tx, eng_rsp, eng_op, exp_tx;
    logic [23:0] eng_addr;

    always @(negedge core_clk) begin
        eng_done = 1'b0;
        if (!core_rstn) begin
            eng_wait = 0;
            eng_k    = 0;
        end else begin
            if (spi_cs_n) eng_k = 0;
            if (eng_wait > 0) begin
                checks++;
                if (eng_start !== 1'b0 || eng_tx !== eng_hold_tx) begin
                    failures++;
                    $display("FAIL eng_hold: start=%0b tx=%02h, required start=0 tx=%02h", eng_start, eng_tx, eng_hold_tx);
                end
                eng_wait--;
                if (eng_wait == 0) begin
                    eng_rx       = eng_rsp;
                    eng_done     = 1'b1;
                    t_done_drive = cyc;
                end
            end else if (eng_start === 1'b1) begin
                eng_hold_tx = eng_tx;
                checks++;
                if (tx_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL eng_tx_extra: got %02h, required no byte", eng_tx);
                end else begin
                    exp_tx = tx_exp_q.pop_front();
                    if (eng_tx !== exp_tx) begin
                        failures++;
                        $display("FAIL eng_tx: got %02h, required %02h", eng_tx, exp_tx);
                    end
                end
                if (eng_k == 0) eng_op = eng_tx;
                else if (eng_k <= 3) eng_addr = {eng_addr[15:0], eng_tx};
                eng_rsp  = flash_byte(eng_op, eng_addr, eng_k);
                eng_k++;
                eng_wait = ENG_LAT;
            end
        end
    end

    // Output monitor: rx scoreboard, ready pulses, chip-select timing.
    logic            prev_cs = 1'b1;
    logic            first_start_pending = 1'b0;
    logic [NREQ-1:0] prev_ready = '0;
    rx_exp_t         rx_exp;

    always @(negedge core_clk) begin
        if (!core_rstn) begin
            prev_cs             = 1'b1;
            first_start_pending = 1'b0;
            prev_ready          = '0;
        end else begin
            if (rx_valid === 1'b1) begin
                rx_cnt++;
                if (rx_last) rx_last_cnt++;
                checks++;
                if (rx_exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rx_extra: got id=%0d data=%02h last=%0b, required none", rx_id, rx_data, rx_last);
                end else begin
                    rx_exp = rx_exp_q.pop_front();
                    if ({rx_id, rx_data, rx_last} !== rx_exp) begin
                        failures++;
                        $display("FAIL rx_byte: got id=%0d data=%02h last=%0b, required id=%0d data=%02h last=%0b",
                                 rx_id, rx_data, rx_last, rx_exp.id, rx_exp.data, rx_exp.last);
                    end
                end
            end
            if (eng_start === 1'b1) start_cnt++;
            if (req_ready !== '0) begin
                checks++;
                if (prev_ready !== '0 || (req_ready !== 2'b01 && req_ready !== 2'b10)) begin
                    failures++;
                    $display("FAIL ready_pulse: got %02b after %02b, required one-hot single cycle", req_ready, prev_ready);
                end
                grant_log.push_back(req_ready[1] ? 1 : 0);
            end
            prev_ready = req_ready;
            if (!spi_cs_n) cs_low_cyc++;
            if (prev_cs && !spi_cs_n) begin
                cs_fall_cnt++;
                t_cs_fall           = cyc;
                first_start_pending = 1'b1;
            end
            if (eng_start === 1'b1 && first_start_pending) begin
                first_start_pending = 1'b0;
                checks++;
                if (cyc - t_cs_fall != CS_SETUP) begin
                    failures++;
                    $display("FAIL cs_setup: got %0d cycles, required %0d", cyc - t_cs_fall, CS_SETUP);
                end
            end
            // A done driven in cycle c is consumed at edge c+1; cs must rise CS_HOLD edges later.
            if (!prev_cs && spi_cs_n) begin
                checks++;
                if (cyc - t_done_drive != CS_HOLD + 1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL cs_hold: got %0d cycles busy=%0b, required %0d busy=0",
                             cyc - t_done_drive - 1, busy, CS_HOLD);
                end
            end
            prev_cs = spi_cs_n;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_expect(input int id, input logic [7:0] op, input logic [23:0] addr,
                               input logic aen, input logic [7:0] rlen);
        rx_exp_t e;
        tx_exp_q.push_back(op);
        if (aen) begin
            tx_exp_q.push_back(addr[23:16]);
            tx_exp_q.push_back(addr[15:8]);
            tx_exp_q.push_back(addr[7:0]);
        end
        for (int k = 0; k < int'(rlen); k++) begin
            tx_exp_q.push_back(8'h00);
            e.id   = 1'(id);
            e.data = (op == OP_READ && aen) ? mem[(int'(addr[7:0]) + k) % 256] : mem[k % 256];
            e.last = (k == int'(rlen) - 1);
            rx_exp_q.push_back(e);
        end
    endtask

    task automatic drive_req(input int id, input logic [7:0] op, input logic [23:0] addr,
                             input logic aen, input logic [7:0] rlen);
        req_opcode[id*8 +: 8]   = op;
        req_addr[id*24 +: 24]   = addr;
        req_addr_en[id]         = aen;
        req_rlen[id*LEN_W +: 8] = rlen;
        req_valid[id]           = 1'b1;
    endtask

    task automatic wait_ready(input int id);
        int n = 0;
        while (req_ready[id] !== 1'b1 && n < 100) begin
            @(negedge core_clk);
            n++;
        end
        checks++;
        if (req_ready[id] !== 1'b1) begin
            failures++;
            $display("FAIL ready_timeout: requester %0d got no req_ready in %0d cycles", id, n);
        end
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge core_clk);
        while (!(busy === 1'b0 && spi_cs_n === 1'b1) && n < budget) begin
            @(negedge core_clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0 || spi_cs_n !== 1'b1 || rx_exp_q.size() != 0 || tx_exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_done: busy=%0b cs_n=%0b rx_left=%0d tx_left=%0d, required 0 1 0 0",
                     name, busy, spi_cs_n, rx_exp_q.size(), tx_exp_q.size());
        end
        repeat (2) @(negedge core_clk);
    endtask

    task automatic test_reset();
        logic [23:0] got;
        core_rstn   = 1'b0;
        req_valid   = '0;
        req_opcode  = '0;
        req_addr    = '0;
        req_addr_en = '0;
        req_rlen    = '0;
        #12;
        got = {spi_cs_n, busy, eng_start, rx_valid, rx_last, req_ready, eng_tx, rx_data, rx_id};
        checks++;
        if (got !== {1'b1, 23'b0}) begin
            failures++;
            $display("FAIL reset_state: got %06h, required 800000", got);
        end
        @(negedge core_clk);
        core_rstn = 1'b1;
        repeat (2) @(negedge core_clk);
    endtask

    task automatic test_single_read();
        int rx0 = rx_cnt, cs0 = cs_fall_cnt, l0 = rx_last_cnt;
        grant_log.delete();
        push_expect(0, OP_READ, 24'h000000, 1'b1, 8'd4);
        drive_req(0, OP_READ, 24'h000000, 1'b1, 8'd4);
        wait_ready(0);
        wait_idle("single_read", 200);
        checks++;
        if (rx_cnt - rx0 != 4 || rx_last_cnt - l0 != 1 || cs_fall_cnt - cs0 != 1 || grant_log.size() != 1) begin
            failures++;
            $display("FAIL single_read_counts: rx=%0d last=%0d cs_low=%0d grants=%0d, required 4 1 1 1",
                     rx_cnt - rx0, rx_last_cnt - l0, cs_fall_cnt - cs0, grant_log.size());
        end
    endtask

    task automatic test_cmd_only();
        int rx0 = rx_cnt, st0 = start_cnt, low0 = cs_low_cyc;
        grant_log.delete();
        push_expect(1, OP_WAKE, 24'h0, 1'b0, 8'd0);
        drive_req(1, OP_WAKE, 24'h0, 1'b0, 8'd0);
        wait_ready(1);
        wait_idle("cmd_only", 200);
        checks++;
        if (start_cnt - st0 != 1 || rx_cnt - rx0 != 0 || cs_low_cyc - low0 != CS_SETUP + BYTE_T + CS_HOLD) begin
            failures++;
            $display("FAIL cmd_only: starts=%0d rx=%0d cs_low_cycles=%0d, required 1 0 %0d",
                     start_cnt - st0, rx_cnt - rx0, cs_low_cyc - low0, CS_SETUP + BYTE_T + CS_HOLD);
        end
    endtask

    task automatic test_contention();
        int cs0 = cs_fall_cnt, rx0 = rx_cnt, n = 0;
        grant_log.delete();
        for (int t = 0; t < 4; t++) begin
            if (t % 2 == 0) push_expect(0, OP_READ, 24'h000010, 1'b1, 8'd2);
            else            push_expect(1, OP_RDID, 24'h0, 1'b0, 8'd3);
        end
        drive_req(0, OP_READ, 24'h000010, 1'b1, 8'd2);
        drive_req(1, OP_RDID, 24'h0, 1'b0, 8'd3);
        while (grant_log.size() < 4 && n < 600) begin
            @(negedge core_clk);
            n++;
        end
        req_valid = '0;
        wait_idle("contention", 300);
        checks++;
        if (grant_log.size() != 4 || grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
            failures++;
            $display("FAIL contention_order: got %0d grants %p, required 0,1,0,1", grant_log.size(), grant_log);
        end
        checks++;
        if (cs_fall_cnt - cs0 != 4 || rx_cnt - rx0 != 10) begin
            failures++;
            $display("FAIL contention_counts: cs_low=%0d rx=%0d, required 4 10", cs_fall_cnt - cs0, rx_cnt - rx0);
        end
    endtask

    task automatic test_boundary();
        int rx0 = rx_cnt, l0 = rx_last_cnt;
        push_expect(1, OP_RDID, 24'h0, 1'b0, 8'd255);
        drive_req(1, OP_RDID, 24'h0, 1'b0, 8'd255);
        wait_ready(1);
        wait_idle("boundary", 2000);
        checks++;
        if (rx_cnt - rx0 != 255 || rx_last_cnt - l0 != 1) begin
            failures++;
            $display("FAIL boundary_counts: rx=%0d last=%0d, required 255 1", rx_cnt - rx0, rx_last_cnt - l0);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0, l0 = rx_last_cnt;
        push_expect(0, OP_READ, 24'h000020, 1'b1, 8'd4);
        drive_req(0, OP_READ, 24'h000020, 1'b1, 8'd4);
        wait_ready(0);
        while (!(rx_valid === 1'b1 && eng_start === 1'b1) && n < 200) begin
            @(negedge core_clk);
            n++;
        end
        checks++;
        if (rx_valid !== 1'b1 || eng_start !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_reach: rx_valid=%0b eng_start=%0b, required 1 1", rx_valid, eng_start);
        end
        #2 core_rstn = 1'b0;
        #1;
        checks++;
        if (spi_cs_n !== 1'b1 || busy !== 1'b0 || rx_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: cs_n=%0b busy=%0b rx_valid=%0b, required 1 0 0", spi_cs_n, busy, rx_valid);
        end
        rx_exp_q.delete();
        tx_exp_q.delete();
        req_valid = '0;
        repeat (2) @(negedge core_clk);
        core_rstn = 1'b1;
        @(negedge core_clk);
        checks++;
        if (rx_last_cnt != l0) begin
            failures++;
            $display("FAIL reset_no_last: got %0d rx_last, required 0", rx_last_cnt - l0);
        end
        grant_log.delete();
        push_expect(0, OP_READ, 24'h000000, 1'b1, 8'd4);
        push_expect(1, OP_RDID, 24'h0, 1'b0, 8'd2);
        drive_req(0, OP_READ, 24'h000000, 1'b1, 8'd4);
        drive_req(1, OP_RDID, 24'h0, 1'b0, 8'd2);
        wait_ready(0);
        wait_ready(1);
        wait_idle("after_reset", 300);
        checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            failures++;
            $display("FAIL after_reset_order: got %0d grants %p, required 0,1", grant_log.size(), grant_log);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'((i * 7 + 5) & 8'hFF);
        mem[0] = 8'h93;
        mem[1] = 8'h01;
        mem[2] = 8'h00;
        mem[3] = 8'h13;

        test_reset();
        test_single_read();
        test_cmd_only();
        test_contention();
        test_boundary();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
